// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// spi_pkg : shared types and sizing helpers for the SPI receive path
// Revision: 1.0
// =============================================================================
package spi_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } spi_rx_state_t;

    localparam int SPI_WORD_W    = 16;
    localparam int SPI_ERR_CNT_W = 8;

    // Width of a counter/pointer that must hold the value n itself (or a wrap bit).
    function automatic int log2_plus1(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rx_sync.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// spi_rx_sync : equal-depth synchroniser for cs_l/sclk/data plus registered edge detect
// Revision: 1.0
// =============================================================================
module spi_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic cs_l,
    input  logic sclk,
    input  logic data,
    output logic cs_l_sync,
    output logic data_sync,
    output logic cs_rise,
    output logic cs_fall,
    output logic sclk_rise
);

    logic [2:0] synced;   // {cs_l, sclk, data}
    logic       cs_q;
    logic       sclk_q;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign synced = {cs_l, sclk, data};
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][2:0] stage;

            always_ff @(posedge clk_i or posedge arst_i) begin
                if (arst_i) begin
                    stage <= {SYNC_STAGES{3'b100}};
                end else begin
                    stage[0] <= {cs_l, sclk, data};
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign synced = stage[SYNC_STAGES-1];
        end
    endgenerate

    // Edges and data are registered together so the FSM sees them aligned.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            data_sync <= 1'b0;
            cs_rise   <= 1'b0;
            cs_fall   <= 1'b0;
            sclk_rise <= 1'b0;
        end else begin
            cs_q      <= synced[2];
            sclk_q    <= synced[1];
            data_sync <= synced[0];
            cs_rise   <= synced[2] & ~cs_q;
            cs_fall   <= ~synced[2] & cs_q;
            sclk_rise <= synced[1] & ~sclk_q;
        end
    end

    assign cs_l_sync = cs_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// spi_slave_rx : SPI mode-0 word receiver with receive FIFO and valid/ready output.
// Optional macro SPI_RX_FRAME_ERR_EN adds frame_err_o / frame_err_cnt_o.
// Revision: 1.0
// =============================================================================
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int WORD_W      = SPI_WORD_W,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      spi_cs_l_i,
    input  logic                      spi_sclk_i,
    input  logic                      spi_data_i,
    output logic [WORD_W-1:0]         rx_data_o,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    output logic                      overflow_o,
    input  logic                      clear_i,
    output logic [$clog2(WORD_W):0]   bit_cnt_o,
    output logic                      busy_o
`ifdef SPI_RX_FRAME_ERR_EN
    ,
    output logic                      frame_err_o,
    output logic [SPI_ERR_CNT_W-1:0]  frame_err_cnt_o
`endif
);

    localparam int CNT_W = log2_plus1(WORD_W);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = log2_plus1(DEPTH);

    logic cs_l_sync, data_sync, cs_rise, cs_fall, sclk_rise;

    spi_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .cs_l      (spi_cs_l_i),
        .sclk      (spi_sclk_i),
        .data      (spi_data_i),
        .cs_l_sync (cs_l_sync),
        .data_sync (data_sync),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .sclk_rise (sclk_rise)
    );

    spi_rx_state_t     state, state_nxt;
    logic [WORD_W-2:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] shift_word;
    logic              shift_en, push, cnt_clr;

    assign shift_word = {shreg, data_sync};

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // cs_rise is tested first so a coincident sclk edge is dropped.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        push      = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = RECV;
                    cnt_clr   = 1'b1;
                end
            end
            RECV: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    cnt_clr   = 1'b1;
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                    push     = (bit_cnt == CNT_W'(WORD_W - 1));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (cnt_clr) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= shift_word[WORD_W-2:0];
            bit_cnt <= push ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    // Receive FIFO: extra pointer MSB separates full from empty.
    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              empty, full, pop, wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && rx_ready_i;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= shift_word;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && full && !pop) overflow_o <= 1'b1;
            else if (clear_i)         overflow_o <= 1'b0;
        end
    end

    assign rx_valid_o = !empty;
    assign rx_data_o  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign bit_cnt_o  = bit_cnt;
    assign busy_o     = ~cs_l_sync;

`ifdef SPI_RX_FRAME_ERR_EN
    logic frame_err;
    assign frame_err = (state == RECV) && cs_rise && (bit_cnt != '0);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            frame_err_o     <= 1'b0;
            frame_err_cnt_o <= '0;
        end else begin
            frame_err_o <= frame_err;
            if (clear_i)
                frame_err_cnt_o <= '0;
            else if (frame_err && (frame_err_cnt_o != '1))
                frame_err_cnt_o <= frame_err_cnt_o + SPI_ERR_CNT_W'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_spi_slave_rx : two receivers (SYNC_STAGES 2 and 0) fed from one SPI stream,
// checked against a word-queue model.
// Revision: 1.0
// =============================================================================
module tb_spi_slave_rx;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int H     = 3;   // clocks per sclk level, enough for two sync stages

    logic clk = 1'b0, arst = 1'b1, cs_l = 1'b1, sclk = 1'b0, mosi = 1'b0, clear = 1'b0;
    logic rdy0 = 1'b0, rdy2 = 1'b0;
    logic [W-1:0] data0, data2;
    logic valid0, valid2, ovf0, ovf2, busy0, busy2;
    logic [4:0] bc0, bc2;
`ifdef SPI_RX_FRAME_ERR_EN
    logic fe0, fe2;
    logic [7:0] fec0, fec2;
    int fe_pulses0 = 0, fe_pulses2 = 0;
`endif

    int checks = 0, failures = 0;
    int cyc = 0, last_rise = 0, lat0 = -1, lat2 = -1, exp_fe = 0;
    logic [W-1:0] q0[$], q2[$];
    logic exp_ovf0 = 1'b0, exp_ovf2 = 1'b0;
    bit rand_rdy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    spi_slave_rx #(.WORD_W(W), .SYNC_STAGES(2), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .arst_i(arst), .spi_cs_l_i(cs_l), .spi_sclk_i(sclk), .spi_data_i(mosi),
        .rx_data_o(data2), .rx_valid_o(valid2), .rx_ready_i(rdy2), .overflow_o(ovf2),
        .clear_i(clear), .bit_cnt_o(bc2), .busy_o(busy2)
`ifdef SPI_RX_FRAME_ERR_EN
        , .frame_err_o(fe2), .frame_err_cnt_o(fec2)
`endif
    );

    spi_slave_rx #(.WORD_W(W), .SYNC_STAGES(0), .DEPTH(DEPTH)) dut0 (
        .clk_i(clk), .arst_i(arst), .spi_cs_l_i(cs_l), .spi_sclk_i(sclk), .spi_data_i(mosi),
        .rx_data_o(data0), .rx_valid_o(valid0), .rx_ready_i(rdy0), .overflow_o(ovf0),
        .clear_i(clear), .bit_cnt_o(bc0), .busy_o(busy0)
`ifdef SPI_RX_FRAME_ERR_EN
        , .frame_err_o(fe0), .frame_err_cnt_o(fec0)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare: every accepted word must be the next one the model expects.
    always @(negedge clk) begin
        if (arst) begin
`ifdef SPI_RX_FRAME_ERR_EN
            fe_pulses0 = 0;
            fe_pulses2 = 0;
`endif
        end else begin
            if (valid0 && lat0 < 0) lat0 = cyc - last_rise;
            if (valid2 && lat2 < 0) lat2 = cyc - last_rise;
            if (valid0 && rdy0) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_word0: got %0h expected none", data0);
                end else check("word0", 32'(data0), 32'(q0.pop_front()));
            end
            if (valid2 && rdy2) begin
                if (q2.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_word2: got %0h expected none", data2);
                end else check("word2", 32'(data2), 32'(q2.pop_front()));
            end
            if (!valid0) check("empty_data0", 32'(data0), 32'h0);
            if (!valid2) check("empty_data2", 32'(data2), 32'h0);
`ifdef SPI_RX_FRAME_ERR_EN
            if (fe0) fe_pulses0++;
            if (fe2) fe_pulses2++;
`endif
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        if (rand_rdy) begin
            rdy0 = 1'($urandom_range(0, 1));
            rdy2 = rdy0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_rdy(input logic v);
        rdy0 = v;
        rdy2 = v;
    endtask

    // A full FIFO with the consumer stalled loses the new word.
    task automatic model_push(input logic [W-1:0] w);
        if (!rdy0 && q0.size() >= DEPTH) exp_ovf0 = 1'b1; else q0.push_back(w);
        if (!rdy2 && q2.size() >= DEPTH) exp_ovf2 = 1'b1; else q2.push_back(w);
    endtask

    // Ready pulses timed onto each instance's landing edge (final rise + 2 / + 4 clocks).
    task automatic land_pop();
        tick();
        rdy0 = 1'b1; tick(); rdy0 = 1'b0;
        tick();
        rdy2 = 1'b1; tick(); rdy2 = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int nbits, input int gap, input bit pop_on_land);
        cs_l = 1'b0;
        ticks(H);
        for (int i = 0; i < nbits; i++) begin
            mosi = w[W-1-i];
            sclk = 1'b0;
            ticks(H);
            if (i == W-1) begin
                last_rise = cyc;
                if (pop_on_land) begin
                    q0.push_back(w);
                    q2.push_back(w);
                end else model_push(w);
            end
            sclk = 1'b1;
            if (i == W-1 && pop_on_land) land_pop(); else ticks(H);
        end
        sclk = 1'b0;
        ticks(H);
        if (nbits > 0 && nbits < W) begin
            check("partial_cnt0", 32'(bc0), 32'(nbits));
            check("partial_cnt2", 32'(bc2), 32'(nbits));
            check("partial_busy2", 32'(busy2), 32'h1);
            exp_fe++;
        end
        cs_l = 1'b1;
        ticks(gap);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_q0_empty"}, 32'(q0.size()), 32'h0);
        check({tag, "_q2_empty"}, 32'(q2.size()), 32'h0);
        check({tag, "_valid0"}, 32'(valid0), 32'h0);
        check({tag, "_valid2"}, 32'(valid2), 32'h0);
        check({tag, "_ovf0"}, 32'(ovf0), 32'(exp_ovf0));
        check({tag, "_ovf2"}, 32'(ovf2), 32'(exp_ovf2));
`ifdef SPI_RX_FRAME_ERR_EN
        check({tag, "_fe_cnt0"}, 32'(fec0), 32'(exp_fe));
        check({tag, "_fe_cnt2"}, 32'(fec2), 32'(exp_fe));
        check({tag, "_fe_pulses0"}, 32'(fe_pulses0), 32'(exp_fe));
        check({tag, "_fe_pulses2"}, 32'(fe_pulses2), 32'(exp_fe));
`endif
    endtask

    initial begin
        #1000000;
        failures++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        ticks(2);
        check("rst_valid2", 32'(valid2), 32'h0);
        check("rst_data2", 32'(data2), 32'h0);
        check("rst_ovf2", 32'(ovf2), 32'h0);
        check("rst_busy2", 32'(busy2), 32'h0);
        check("rst_cnt2", 32'(bc2), 32'h0);
        check("rst_valid0", 32'(valid0), 32'h0);
        arst = 1'b0;
        ticks(2);

        // Single word, consumer stalled to observe landing latency.
        send_word(16'hA5C3, W, 2, 1'b0);
        check("latency0", 32'(lat0), 32'd2);
        check("latency2", 32'(lat2), 32'd4);
        check("t1_valid2", 32'(valid2), 32'h1);
        check("t1_head2", 32'(data2), 32'hA5C3);
        set_rdy(1'b1);
        ticks(4);
        check_quiet("t1");

        // Back-to-back words with a one-clock chip-select gap.
        send_word(16'h0001, W, 1, 1'b0);
        send_word(16'h8000, W, 1, 1'b0);
        send_word(16'hFFFF, W, 1, 1'b0);
        ticks(6);
        check_quiet("t2");

        // Overflow: fifth word dropped, flag sticky until cleared.
        set_rdy(1'b0);
        for (int k = 1; k <= 5; k++) send_word(W'(k), W, 2, 1'b0);
        ticks(4);
        check("t3_ovf0", 32'(ovf0), 32'h1);
        check("t3_ovf2", 32'(ovf2), 32'h1);
        check("t3_head0", 32'(data0), 32'h1);
        set_rdy(1'b1);
        ticks(8);
        check_quiet("t3");
        clear = 1'b1; tick(); clear = 1'b0; tick();
        exp_ovf0 = 1'b0;
        exp_ovf2 = 1'b0;
        check("t3_clear_ovf0", 32'(ovf0), 32'h0);
        check("t3_clear_ovf2", 32'(ovf2), 32'h0);

        // Full FIFO with a pop on the landing edge: nothing lost.
        set_rdy(1'b0);
        for (int k = 1; k <= 4; k++) send_word(W'(k), W, 2, 1'b0);
        send_word(16'h0005, W, 2, 1'b1);
        ticks(2);
        check("t4_ovf0", 32'(ovf0), 32'h0);
        check("t4_ovf2", 32'(ovf2), 32'h0);
        set_rdy(1'b1);
        ticks(8);
        check_quiet("t4");

        // Truncated frame is discarded, next word clean.
        send_word(16'hFE00, 7, 2, 1'b0);
        send_word(16'h1234, W, 2, 1'b0);
        ticks(6);
        check("t5_cnt2", 32'(bc2), 32'h0);
        check("t5_busy2", 32'(busy2), 32'h0);
        check_quiet("t5");

        // Asynchronous reset in the middle of a word with data queued.
        set_rdy(1'b0);
        send_word(16'h1111, W, 2, 1'b0);
        send_word(16'h2222, W, 2, 1'b0);
        cs_l = 1'b0;
        ticks(H);
        for (int i = 0; i < 9; i++) begin
            mosi = 1'($urandom_range(0, 1));
            sclk = 1'b0; ticks(H);
            sclk = 1'b1; ticks(H);
        end
        sclk = 1'b0;
        ticks(H);
        check("t6_cnt0", 32'(bc0), 32'd9);
        check("t6_cnt2", 32'(bc2), 32'd9);
        @(negedge clk); #2;
        arst = 1'b1;
        cs_l = 1'b1;
        #1;
        check("t6_valid0", 32'(valid0), 32'h0);
        check("t6_valid2", 32'(valid2), 32'h0);
        check("t6_cnt_rst0", 32'(bc0), 32'h0);
        check("t6_cnt_rst2", 32'(bc2), 32'h0);
        q0.delete();
        q2.delete();
        exp_fe = 0;
        ticks(3);
        arst = 1'b0;
        ticks(2);
        set_rdy(1'b1);
        send_word(16'hBEEF, W, 2, 1'b0);
        ticks(6);
        check_quiet("t6");

        // Random words, random truncations, random consumer stalls.
        rand_rdy = 1'b1;
        for (int n = 0; n < 24; n++) begin
            automatic logic [W-1:0] w = W'($urandom);
            automatic int nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W-1)) : W;
            send_word(w, nb, int'($urandom_range(1, 4)), 1'b0);
        end
        rand_rdy = 1'b0;
        set_rdy(1'b1);
        ticks(10);
        check_quiet("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
